serial_adder: RTL
=================

# serial_adder

Bit-serial WIDTH-bit adder. It accepts two parallel operands and a carry-in on a start strobe, then adds them LSB-first, one bit per clock, through a single one-bit full-adder cell and a registered carry. It presents the parallel sum and carry-out with a one-cycle done pulse. It sits upstream of wide datapath consumers as an area-minimal alternative to a ripple-carry array, trading WIDTH cycles of latency for one adder cell.

## Interface

Clock and reset: one clock; reset is asynchronous and active-low.

Parameters:
- WIDTH, 8, operand/sum width in bits; legal range 2..32.

Ports:
- clk    in   1      rising-edge clock
- rst_n  in   1      asynchronous active-low reset
- start  in   1      request strobe; sampled only when busy=0
- a      in   WIDTH  operand A; captured on accepted start
- b      in   WIDTH  operand B; captured on accepted start
- cin    in   1      carry-in; captured on accepted start
- busy   out  1      high while an addition is in progress
- done   out  1      one-cycle pulse when sum/cout become valid
- sum    out  WIDTH  result register; holds the last completed sum
- cout   out  1      carry-out of the last completed addition

## Operation

- States: IDLE, RUN, DONE. Encode them in 2 bits.
- Accepted start: start=1 while in IDLE or DONE.
  - Load a into shift register a_sr and b into b_sr.
  - Load cin into carry_q.
  - Clear the bit counter to 0.
  - Enter RUN.
- RUN, each cycle:
  - Feed the cell with a_sr[0], b_sr[0] and carry_q.
  - Shift a_sr and b_sr right by one.
  - Shift acc_sr right, inserting the cell's sum bit at the MSB.
  - Update carry_q with the cell's carry-out.
  - Increment the counter.
- Exit from RUN: on the cycle the counter equals WIDTH-1, the last bit is processed and the next state is DONE.
- On entering DONE:
  - sum is loaded from the completed acc_sr, including the final bit.
  - cout is loaded with the final carry.
  - done=1 for exactly that one cycle.
  - Without a start, the next state is IDLE.
- Output stability: sum and cout change only on entry to DONE, or on reset. They are stable throughout RUN and hold indefinitely in IDLE.
- start while in RUN is ignored. It is not queued, and operands are not re-sampled.
- Arithmetic: {cout, sum} = a + b + cin, computed modulo 2^(WIDTH+1). There is no overflow flag.
- Counter width: $clog2(WIDTH). The counter does not wrap during a legal run.
- Reset (asserted at any time, including mid-RUN):
  - State returns to IDLE.
  - busy=0, done=0, sum=0, cout=0.
  - Internal shift registers, carry_q and counter clear to 0.
  - The aborted operation produces no done pulse.
  - Release is synchronous to clk; the first accepted start can be on the first edge after release.

## Timing

- Start accepted at edge T0: busy=1 from T0+ through the edge T0+WIDTH.
- Completion: sum/cout are valid and done=1 in the cycle following edge T0+WIDTH. Latency from start to done is WIDTH+1 cycles.
- busy is 0 in the DONE cycle.
- Back-to-back: start asserted during the done cycle is accepted. busy goes high the next cycle, and sum/cout keep the previous result until the new DONE.
- Combinational paths: none from inputs to outputs. All outputs are registered.
- Critical path: one full-adder cell plus the shift/carry register setup, independent of WIDTH.

## Structure

- Shared package/header:
  - State encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_DONE=2'd2.
  - The WIDTH default.
- Sub-module: instantiate the team's existing combinational full_adder cell (ports a, b, cin, sum, cout) exactly once for the bit slice. Do not inline the sum/carry equations.
- Sequential logic: a single always block for the state, counter, shift registers and carry, plus an output register block.

## Test plan

- Basic add: WIDTH=8, a=8'h0F, b=8'h01, cin=0, start at T0 -> done in the cycle after T0+8 with sum=8'h10, cout=0. busy is high for exactly 8 cycles.
- Carry propagation: a=8'hFF, b=8'h01, cin=0 -> sum=8'h00, cout=1. Then a=8'hFF, b=8'hFF, cin=1 -> sum=8'hFF, cout=1.
- Ignored start: start pulsed with a=8'h01, b=8'h01 at cycle 3 of a run of 8'h22+8'h11 -> single done with sum=8'h33, cout=0. No second done follows.
- Reset mid-run: rst_n low at cycle 4 of 8'hAA+8'h55 -> sum=0, cout=0, busy=0 immediately, and no done pulse. A fresh start of 8'h03+8'h04 after release -> sum=8'h07.
- Back-to-back: start of 8'h10+8'h20 held high in the done cycle of the previous run -> accepted with no idle gap, done after 9 more cycles with sum=8'h30. The previous sum holds until then.
- Random: 1000 random a/b/cin at WIDTH=8 and WIDTH=2 -> {cout, sum} matches a+b+cin on every done.

Source files
------------

// File: rtl/serial_adder_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encoding and default width.
package serial_adder_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_adder_full_adder.sv
// One-bit combinational full-adder cell; the single arithmetic element of the serial adder.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    // Sum and carry of three one-bit inputs
    always_comb begin
        sum  = a ^ b ^ cin;
        cout = (a & b) | (a & cin) | (b & cin);
    end

endmodule

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: operands are shifted LSB-first through one full-adder
// cell with a registered carry; the parallel result is published with a done pulse.
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t           state;
    state_t           next_state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    // Holds the WIDTH-1 most recent sum bits; the bit being produced this cycle
    // completes the word, so the register never needs to hold all WIDTH bits.
    logic [WIDTH-2:0] acc_sr;
    logic [WIDTH-1:0] acc_full;
    logic             carry_q;
    logic [CNT_W-1:0] cnt;
    logic             fa_sum;
    logic             fa_cout;
    logic             accept;
    logic             last_bit;

    assign accept   = start && (state != ST_RUN);
    assign last_bit = (state == ST_RUN) && (cnt == CNT_W'(WIDTH - 1));
    assign acc_full = {fa_sum, acc_sr};

    full_adder u_cell (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry_q),
        .sum  (fa_sum),
        .cout (fa_cout)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; a start in DONE chains directly into the next run
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: next_state = start ? ST_RUN : ST_IDLE;
            ST_RUN:  next_state = last_bit ? ST_DONE : ST_RUN;
            ST_DONE: next_state = start ? ST_RUN : ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Status outputs decoded from the state register only
    always_comb begin
        busy = (state == ST_RUN);
        done = (state == ST_DONE);
    end

    // Operand capture, per-bit shifting, carry and bit counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            acc_sr  <= '0;
            carry_q <= 1'b0;
            cnt     <= '0;
        end else if (accept) begin
            a_sr    <= a;
            b_sr    <= b;
            carry_q <= cin;
            cnt     <= '0;
        end else if (state == ST_RUN) begin
            a_sr    <= {1'b0, a_sr[WIDTH-1:1]};
            b_sr    <= {1'b0, b_sr[WIDTH-1:1]};
            acc_sr  <= acc_full[WIDTH-1:1];
            carry_q <= fa_cout;
            cnt     <= cnt + CNT_W'(1);
        end
    end

    // Result register; updated only on the edge that enters DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum  <= '0;
            cout <= 1'b0;
        end else if (last_bit) begin
            sum  <= acc_full;
            cout <= fa_cout;
        end
    end

endmodule
